// File: rtl/accum_frame_ctrl_if.sv
// Sample-in and result-out streams of the accumulator frame controller.
// The slave modport is the controller's view; master is the source/sink view.
interface accum_frame_ctrl_if #(
  parameter int DIN_WIDTH  = 32,
  parameter int DOUT_WIDTH = 32
);
  logic                  s_valid;
  logic [DIN_WIDTH-1:0]  s_data;
  logic                  s_ready;
  logic                  m_valid;
  logic                  m_ready;
  logic [DOUT_WIDTH-1:0] m_result;
  logic                  m_ovf;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_result, m_ovf
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_result, m_ovf
  );
endinterface

// File: rtl/accum_frame_ctrl.sv
// Frame sequencer for an external signed accumulator.
// Flow: clear, stream frame_len samples, then hand out the sum with a sticky overflow flag.
module accum_frame_ctrl #(
  parameter int DIN_WIDTH  = 32,
  parameter int DOUT_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  acc_clear,
  output logic                  acc_enable,
  output logic [DIN_WIDTH-1:0]  acc_data,
  input  logic [DOUT_WIDTH-1:0] acc_result,
  accum_frame_ctrl_if.slave     bus
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic [LEN_WIDTH-1:0] len;
  logic [LEN_WIDTH-1:0] count;
  logic                 ovf;
  logic                 a_sgn;
  logic                 d_sgn;
  logic                 chk_pend;

  logic                 s_ready;
  logic                 m_valid;
  logic                 accept;
  logic                 last;
  logic                 start_take;
  logic                 abort_take;
  logic                 result_take;

  assign last = (count == len - LEN_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    busy        = (state != IDLE);
    s_ready     = 1'b0;
    acc_clear   = 1'b0;
    acc_enable  = 1'b0;
    m_valid     = 1'b0;
    accept      = 1'b0;
    start_take  = 1'b0;
    abort_take  = 1'b0;
    result_take = 1'b0;

    case (state)
      IDLE: begin
        // start outranks a simultaneous abort because abort has no effect here
        if (start && (frame_len != '0)) begin
          start_take = 1'b1;
          state_nxt  = CLEAR;
        end
      end

      CLEAR: begin
        acc_clear = 1'b1;
        if (abort) begin
          abort_take = 1'b1;
          state_nxt  = IDLE;
        end else begin
          state_nxt = RUN;
        end
      end

      RUN: begin
        if (abort) begin
          abort_take = 1'b1;
          acc_clear  = 1'b1;
          state_nxt  = IDLE;
        end else begin
          s_ready    = 1'b1;
          acc_enable = bus.s_valid;
          accept     = bus.s_valid;
          if (bus.s_valid && last) begin
            state_nxt = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (abort) begin
          abort_take = 1'b1;
          acc_clear  = 1'b1;
          state_nxt  = IDLE;
        end else begin
          state_nxt = DONE;
        end
      end

      DONE: begin
        m_valid = 1'b1;
        if (bus.m_ready) begin
          result_take = 1'b1;
          state_nxt   = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Sign snapshot taken on each accept is compared against the registered sum one cycle later,
  // so a pending check always lines up with the add it belongs to, even back-to-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len      <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      a_sgn    <= 1'b0;
      d_sgn    <= 1'b0;
      chk_pend <= 1'b0;
    end else begin
      chk_pend <= accept;
      if (accept) begin
        a_sgn <= acc_result[DOUT_WIDTH-1];
        d_sgn <= bus.s_data[DIN_WIDTH-1];
        count <= count + LEN_WIDTH'(1);
      end

      if (chk_pend && (a_sgn == d_sgn) && (acc_result[DOUT_WIDTH-1] != a_sgn)) begin
        ovf <= 1'b1;
      end

      if (start_take) begin
        len   <= frame_len;
        count <= '0;
        ovf   <= 1'b0;
      end

      if (abort_take) begin
        count <= '0;
        ovf   <= 1'b0;
      end

      if (result_take) begin
        count <= '0;
      end
    end
  end

  assign acc_data     = bus.s_data;
  assign bus.s_ready  = s_ready;
  assign bus.m_valid  = m_valid;
  assign bus.m_result = m_valid ? acc_result : '0;
  assign bus.m_ovf    = ovf;

endmodule

// File: tb/tb_accum_frame_ctrl.sv
// Bench for accum_frame_ctrl: directed protocol steps plus randomized frames,
// with sums and overflow predicted by plain wide-integer arithmetic.
module tb_accum_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  frame_len;
  logic        abort;
  logic        busy;
  logic        acc_clear;
  logic        acc_enable;
  logic [31:0] acc_data;
  logic [31:0] acc_result;

  int checks   = 0;
  int failures = 0;

  logic [31:0] samp[$];
  bit          vpat[$];

  accum_frame_ctrl_if #(.DIN_WIDTH(32), .DOUT_WIDTH(32)) bus ();

  accum_frame_ctrl #(
    .DIN_WIDTH (32),
    .DOUT_WIDTH(32),
    .LEN_WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .frame_len (frame_len),
    .abort     (abort),
    .busy      (busy),
    .acc_clear (acc_clear),
    .acc_enable(acc_enable),
    .acc_data  (acc_data),
    .acc_result(acc_result),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Environment accumulator: registered, one-cycle update, wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_result <= '0;
    end else if (acc_clear) begin
      acc_result <= '0;
    end else if (acc_enable) begin
      acc_result <= acc_result + acc_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Signed running sum in 64-bit arithmetic; overflow whenever a partial sum leaves the 32-bit range.
  task automatic ref_model(output logic [31:0] sum, output logic ovf);
    longint acc;
    acc = 0;
    ovf = 1'b0;
    foreach (samp[i]) begin
      longint n;
      n = acc + longint'($signed(samp[i]));
      if (n > 64'sd2147483647 || n < -64'sd2147483648) ovf = 1'b1;
      acc = longint'($signed(n[31:0]));
    end
    sum = acc[31:0];
  endtask

  task automatic start_frame(input int len);
    @(negedge clk);
    start     = 1'b1;
    frame_len = 8'(len);
    abort     = 1'($urandom_range(0, 1));
    #1;
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_mvalid", 64'(bus.m_valid), 64'(0));
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    #1;
    chk("clear_pulse", 64'(acc_clear), 64'(1));
    chk("clear_sready", 64'(bus.s_ready), 64'(0));
    chk("clear_busy", 64'(busy), 64'(1));
    chk("clear_ovf", 64'(bus.m_ovf), 64'(0));
  endtask

  task automatic run_accepts(input int n);
    int acc_n;
    int guard;
    bit v;
    acc_n = 0;
    guard = 0;
    while (acc_n < n) begin
      if (guard > 400) begin
        chk("run_timeout", 64'(acc_n), 64'(n));
        break;
      end
      guard++;
      @(negedge clk);
      if (vpat.size() != 0) v = vpat.pop_front();
      else v = ($urandom_range(0, 3) != 0);
      bus.s_valid = v;
      bus.s_data  = v ? samp[acc_n] : $urandom;
      start       = 1'($urandom_range(0, 1));
      frame_len   = 8'($urandom_range(1, 255));
      #1;
      chk("run_sready", 64'(bus.s_ready), 64'(1));
      chk("run_enable", 64'(acc_enable), 64'(v));
      chk("run_clear", 64'(acc_clear), 64'(0));
      if (v) begin
        chk("run_data", 64'(acc_data), 64'(samp[acc_n]));
        acc_n++;
      end
    end
  endtask

  task automatic run_frame(input int hold);
    logic [31:0] esum;
    logic        eovf;
    ref_model(esum, eovf);
    start_frame(samp.size());
    run_accepts(samp.size());
    @(negedge clk);
    start       = 1'b0;
    bus.s_valid = 1'($urandom_range(0, 1));
    #1;
    chk("drain_sready", 64'(bus.s_ready), 64'(0));
    chk("drain_enable", 64'(acc_enable), 64'(0));
    chk("drain_mvalid", 64'(bus.m_valid), 64'(0));
    chk("drain_busy", 64'(busy), 64'(1));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      bus.s_valid  = 1'b0;
      bus.m_ready  = 1'b0;
      abort        = (h == 0);
      start        = (h == 1);
      frame_len    = 8'd3;
      #1;
      chk("hold_mvalid", 64'(bus.m_valid), 64'(1));
      chk("hold_result", 64'(bus.m_result), 64'(esum));
      chk("hold_ovf", 64'(bus.m_ovf), 64'(eovf));
      chk("hold_busy", 64'(busy), 64'(1));
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    abort       = 1'b0;
    start       = 1'b0;
    bus.m_ready = 1'b1;
    #1;
    chk("done_mvalid", 64'(bus.m_valid), 64'(1));
    chk("done_result", 64'(bus.m_result), 64'(esum));
    chk("done_ovf", 64'(bus.m_ovf), 64'(eovf));
    @(negedge clk);
    bus.m_ready = 1'b0;
    #1;
    chk("post_busy", 64'(busy), 64'(0));
    chk("post_mvalid", 64'(bus.m_valid), 64'(0));
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    frame_len   = '0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_sready", 64'(bus.s_ready), 64'(0));
    chk("rst_clear", 64'(acc_clear), 64'(0));
    chk("rst_enable", 64'(acc_enable), 64'(0));
    chk("rst_mvalid", 64'(bus.m_valid), 64'(0));
    chk("rst_ovf", 64'(bus.m_ovf), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // len 4, back-to-back 1..4
    samp = '{32'd1, 32'd2, 32'd3, 32'd4};
    vpat = '{1, 1, 1, 1};
    run_frame(0);

    // len 3 with valid gaps and result back-pressure
    samp = '{32'd100, 32'hFFFF_FFF6, 32'd7};
    vpat = '{1, 0, 0, 1, 0, 1};
    run_frame(5);

    // positive overflow, then a negative frame without overflow, then sticky across re-entry
    samp = '{32'h7FFF_FFFF, 32'd1};
    vpat = '{1, 1};
    run_frame(1);
    samp = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vpat = '{1, 1};
    run_frame(1);
    samp = '{32'h7FFF_FFFF, 32'd1, 32'hFFFF_FFFF};
    vpat = '{1, 1, 1};
    run_frame(0);

    // abort after the 3rd accept of an 8-sample frame that has already overflowed
    samp = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10};
    vpat = '{1, 1, 1};
    start_frame(8);
    run_accepts(3);
    @(negedge clk);
    abort       = 1'b1;
    start       = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'd1234;
    #1;
    chk("abort_sready", 64'(bus.s_ready), 64'(0));
    chk("abort_enable", 64'(acc_enable), 64'(0));
    chk("abort_clear", 64'(acc_clear), 64'(1));
    @(negedge clk);
    abort       = 1'b0;
    bus.s_valid = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_mvalid", 64'(bus.m_valid), 64'(0));
    chk("abort_ovf", 64'(bus.m_ovf), 64'(0));
    chk("abort_clear_once", 64'(acc_clear), 64'(0));
    samp = '{32'd5};
    vpat = '{1};
    run_frame(0);

    // zero-length start is ignored
    @(negedge clk);
    start     = 1'b1;
    frame_len = 8'd0;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("len0_busy", 64'(busy), 64'(0));
    chk("len0_clear", 64'(acc_clear), 64'(0));

    // asynchronous reset in the middle of a frame
    samp = '{32'd11, 32'd22, 32'd33, 32'd44, 32'd55};
    vpat = '{1, 1};
    start_frame(5);
    run_accepts(2);
    @(negedge clk);
    start       = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'd33;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_sready", 64'(bus.s_ready), 64'(0));
    chk("arst_enable", 64'(acc_enable), 64'(0));
    chk("arst_clear", 64'(acc_clear), 64'(0));
    chk("arst_mvalid", 64'(bus.m_valid), 64'(0));
    chk("arst_ovf", 64'(bus.m_ovf), 64'(0));
    @(negedge clk);
    rst         = 1'b0;
    bus.s_valid = 1'b0;
    samp = '{32'd9, 32'd8, 32'd7};
    run_frame(1);

    // randomized frames: full-range and small signed samples
    for (int f = 0; f < 10; f++) begin
      int len;
      len = int'($urandom_range(1, 12));
      samp.delete();
      for (int i = 0; i < len; i++) begin
        if (f % 2 == 0) samp.push_back($urandom);
        else samp.push_back(32'($signed($urandom_range(0, 200)) - 100));
      end
      run_frame(int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
